// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache and its memory-side fill responder.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } fill_state_t;

  function automatic int line_size_bits(input int line_size_bytes);
    return 8 * line_size_bytes;
  endfunction

  // Upper address bits are discarded, so the store aliases by design.
  function automatic logic [63:0] line_index(input logic [63:0] addr,
                                             input int offset_bits,
                                             input int index_bits);
    return (addr >> offset_bits) & ((64'd1 << index_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_line_ram.sv
// Backing line store: synchronous write, combinational read, contents survive reset.
module mem_line_ram #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cache_fill_responder.sv
// Memory-side responder: serves line fills after a fixed latency and absorbs
// dirty-line writebacks through a one-entry buffer.
//   state | meaning
//   IDLE  | waiting for work; buffered writeback first, then new writeback, then fill
//   WB    | writing one line to the store, write on the last cycle
//   FILL  | counting down the fill latency
//   RESP  | one-cycle response pulse with the line read this cycle
module cache_fill_responder
  import cache_mem_pkg::*;
#(
  parameter int LINE_SIZE_BYTES = 4,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int OFFSET_BITS     = 6,
  parameter int MEM_ADDR_BITS   = 10,
  parameter int FILL_LATENCY    = 4,
  parameter int WB_LATENCY      = 2,
  localparam int LINE_SIZE_BITS = line_size_bits(LINE_SIZE_BYTES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_fill_req,
  input  logic [ADDRESS_WIDTH-1:0]  i_fill_addr,
  input  logic                      i_wb_valid,
  input  logic [ADDRESS_WIDTH-1:0]  i_wb_addr,
  input  logic [LINE_SIZE_BITS-1:0] i_wb_data,
  output logic                      o_fill_valid,
  output logic [LINE_SIZE_BITS-1:0] o_fill_line,
  output logic                      o_busy,
  output logic                      o_wb_overflow,
  output logic [15:0]               o_fill_count,
  output logic [15:0]               o_wb_count
);

  fill_state_t state, state_next;
  logic [7:0] cnt, cnt_next;

  logic                      buf_valid;
  logic [MEM_ADDR_BITS-1:0]  buf_idx;
  logic [LINE_SIZE_BITS-1:0] buf_data;
  logic [MEM_ADDR_BITS-1:0]  cur_idx, fill_idx;
  logic [LINE_SIZE_BITS-1:0] cur_data;

  logic [MEM_ADDR_BITS-1:0]  wb_in_idx, fill_in_idx, src_idx;
  logic [LINE_SIZE_BITS-1:0] src_data, rd_data, wr_data;
  logic [MEM_ADDR_BITS-1:0]  wr_idx;
  logic wr_en, wb_start, fill_start, drain;

  assign wb_in_idx   = MEM_ADDR_BITS'(line_index(64'(i_wb_addr), OFFSET_BITS, MEM_ADDR_BITS));
  assign fill_in_idx = MEM_ADDR_BITS'(line_index(64'(i_fill_addr), OFFSET_BITS, MEM_ADDR_BITS));
  assign src_idx     = buf_valid ? buf_idx : wb_in_idx;
  assign src_data    = buf_valid ? buf_data : i_wb_data;
  assign drain       = (state == IDLE) && buf_valid;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wb_start   = 1'b0;
    fill_start = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = cur_idx;
    wr_data    = cur_data;
    case (state)
      IDLE: begin
        if (buf_valid || i_wb_valid) begin
          wb_start = 1'b1;
          if (WB_LATENCY == 1) begin
            wr_en   = 1'b1;
            wr_idx  = src_idx;
            wr_data = src_data;
          end else begin
            state_next = WB;
            cnt_next   = 8'(WB_LATENCY - 1);
          end
        end else if (i_fill_req) begin
          fill_start = 1'b1;
          cnt_next   = 8'(FILL_LATENCY - 1);
          state_next = (FILL_LATENCY == 1) ? RESP : FILL;
        end
      end
      WB: begin
        if (cnt == 8'd1) begin
          wr_en      = 1'b1;
          state_next = IDLE;
        end
        cnt_next = cnt - 8'd1;
      end
      FILL: begin
        if (cnt == 8'd1) state_next = RESP;
        cnt_next = cnt - 8'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      buf_valid     <= 1'b0;
      buf_idx       <= '0;
      buf_data      <= '0;
      cur_idx       <= '0;
      cur_data      <= '0;
      fill_idx      <= '0;
      o_wb_overflow <= 1'b0;
      o_fill_count  <= '0;
      o_wb_count    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (wb_start) begin
        cur_idx  <= src_idx;
        cur_data <= src_data;
      end
      if (fill_start) fill_idx <= fill_in_idx;
      // A pulse taken straight into WB from IDLE never touches the buffer.
      if (i_wb_valid && !(wb_start && !buf_valid)) begin
        if (buf_valid && !drain) begin
          o_wb_overflow <= 1'b1;
        end else begin
          buf_valid <= 1'b1;
          buf_idx   <= wb_in_idx;
          buf_data  <= i_wb_data;
        end
      end else if (drain) begin
        buf_valid <= 1'b0;
      end
      if (wr_en) o_wb_count <= o_wb_count + 16'd1;
      if (state == RESP) o_fill_count <= o_fill_count + 16'd1;
    end
  end

  mem_line_ram #(
    .ADDR_BITS (MEM_ADDR_BITS),
    .DATA_BITS (LINE_SIZE_BITS)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data (wr_data),
    .rd_addr (fill_idx),
    .rd_data (rd_data)
  );

  assign o_fill_valid = (state == RESP);
  assign o_fill_line  = (state == RESP) ? rd_data : '0;
  assign o_busy       = (state != IDLE) || buf_valid;

endmodule

// File: tb/tb_cache_fill_responder.sv
// Directed bench for cache_fill_responder with hand-computed expectations.
module tb_cache_fill_responder;

  logic        clk;
  logic        rst;
  logic        i_fill_req;
  logic [31:0] i_fill_addr;
  logic        i_wb_valid;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_fill_valid;
  logic [31:0] o_fill_line;
  logic        o_busy;
  logic        o_wb_overflow;
  logic [15:0] o_fill_count;
  logic [15:0] o_wb_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_fc = 0;
  int exp_wc = 0;

  cache_fill_responder dut (
    .clk           (clk),
    .rst           (rst),
    .i_fill_req    (i_fill_req),
    .i_fill_addr   (i_fill_addr),
    .i_wb_valid    (i_wb_valid),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .o_fill_valid  (o_fill_valid),
    .o_fill_line   (o_fill_line),
    .o_busy        (o_busy),
    .o_wb_overflow (o_wb_overflow),
    .o_fill_count  (o_fill_count),
    .o_wb_count    (o_wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(o_fill_valid), 64'd0);
    chk({tag, "_line"}, 64'(o_fill_line), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_ovf"}, 64'(o_wb_overflow), 64'd0);
    chk({tag, "_fcnt"}, 64'(o_fill_count), 64'd0);
    chk({tag, "_wcnt"}, 64'(o_wb_count), 64'd0);
  endtask

  // Raise a fill at cycle 0, optionally pulse writebacks at cycles wa / wb2,
  // and check response latency, line and the single-cycle pulse.
  task automatic do_fill(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_line, input int exp_lat,
                         input int wa, input logic [31:0] wa_addr, input logic [31:0] wa_data,
                         input int wb2, input logic [31:0] wb2_addr, input logic [31:0] wb2_data);
    int n;
    n = 0;
    i_fill_req  = 1'b1;
    i_fill_addr = addr;
    while (n < 40) begin
      i_wb_valid = (n == wa) || (n == wb2);
      i_wb_addr  = (n == wb2) ? wb2_addr : wa_addr;
      i_wb_data  = (n == wb2) ? wb2_data : wa_data;
      if (o_fill_valid) break;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_line"}, 64'(o_fill_line), 64'(exp_line));
    tick();
    i_fill_req = 1'b0;
    i_wb_valid = 1'b0;
    exp_fc++;
    chk({tag, "_pulse"}, 64'(o_fill_valid), 64'd0);
    chk({tag, "_fcnt"}, 64'(o_fill_count), 64'(exp_fc));
  endtask

  task automatic wb_alone(input logic [31:0] addr, input logic [31:0] data);
    i_wb_valid = 1'b1;
    i_wb_addr  = addr;
    i_wb_data  = data;
    tick();
    i_wb_valid = 1'b0;
    tick();
    tick();
    exp_wc++;
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    i_fill_req = 1'b0;
    i_fill_addr = '0;
    i_wb_valid = 1'b0;
    i_wb_addr = '0;
    i_wb_data = '0;
    repeat (3) tick();
    check_reset_outputs("rst_held");
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_idle");

    // Zero store, index 1
    do_fill("fill_zero", 32'h0000_0040, 32'h0, 4, -1, '0, '0, -1, '0, '0);

    // Same-cycle writeback and fill to one line: writeback wins, fill sees new data
    do_fill("wb_then_fill", 32'h80, 32'hDEAD_BEEF, 6, 0, 32'h80, 32'hDEAD_BEEF, -1, '0, '0);
    exp_wc++;
    chk("wb_then_fill_wcnt", 64'(o_wb_count), 64'(exp_wc));

    // Writeback mid-fill: fill returns old data, buffer drains afterwards
    do_fill("mid_wb", 32'h40, 32'h0, 4, 2, 32'h40, 32'h1234_5678, -1, '0, '0);
    chk("mid_wb_busy_buf", 64'(o_busy), 64'd1);
    chk("mid_wb_wcnt_pre", 64'(o_wb_count), 64'(exp_wc));
    tick();
    tick();
    exp_wc++;
    chk("mid_wb_wcnt", 64'(o_wb_count), 64'(exp_wc));
    chk("mid_wb_idle", 64'(o_busy), 64'd0);
    do_fill("mid_wb_new", 32'h40, 32'h1234_5678, 4, -1, '0, '0, -1, '0, '0);

    // Two writebacks in one fill: second dropped, overflow sticky
    chk("ovf_before", 64'(o_wb_overflow), 64'd0);
    do_fill("ovf_fill", 32'hC0, 32'h0, 4, 1, 32'hC0, 32'hAAAA_5555, 2, 32'h100, 32'h0BAD_0BAD);
    chk("ovf_set", 64'(o_wb_overflow), 64'd1);
    tick();
    tick();
    exp_wc++;
    chk("ovf_wcnt", 64'(o_wb_count), 64'(exp_wc));
    do_fill("ovf_kept", 32'hC0, 32'hAAAA_5555, 4, -1, '0, '0, -1, '0, '0);
    do_fill("ovf_dropped", 32'h100, 32'h0, 4, -1, '0, '0, -1, '0, '0);
    chk("ovf_sticky", 64'(o_wb_overflow), 64'd1);

    // Reset two cycles into a fill: no response, counters cleared, store kept
    i_fill_req  = 1'b1;
    i_fill_addr = 32'h80;
    tick();
    tick();
    rst = 1'b1;
    #2;
    check_reset_outputs("rst_mid");
    i_fill_req = 1'b0;
    tick();
    rst = 1'b0;
    exp_fc = 0;
    exp_wc = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_fill_valid) seen++;
      tick();
    end
    chk("rst_no_resp", 64'(seen), 64'd0);
    do_fill("rst_refill", 32'h80, 32'hDEAD_BEEF, 4, -1, '0, '0, -1, '0, '0);

    // Writeback arriving as the buffer drains goes into the freed entry
    do_fill("drain_fill", 32'h40, 32'h1234_5678, 4, 2, 32'h140, 32'h1111_1111, -1, '0, '0);
    i_wb_valid = 1'b1;
    i_wb_addr  = 32'h180;
    i_wb_data  = 32'h2222_2222;
    tick();
    i_wb_valid = 1'b0;
    repeat (3) tick();
    exp_wc += 2;
    chk("drain_no_ovf", 64'(o_wb_overflow), 64'd0);
    chk("drain_wcnt", 64'(o_wb_count), 64'(exp_wc));
    chk("drain_idle", 64'(o_busy), 64'd0);
    do_fill("drain_first", 32'h140, 32'h1111_1111, 4, -1, '0, '0, -1, '0, '0);
    do_fill("drain_second", 32'h180, 32'h2222_2222, 4, -1, '0, '0, -1, '0, '0);

    // Upper address bits ignored: 0x10040 aliases onto index 1
    wb_alone(32'h0001_0040, 32'hCAFE_F00D);
    chk("alias_wcnt", 64'(o_wb_count), 64'(exp_wc));
    do_fill("alias", 32'h0000_0040, 32'hCAFE_F00D, 4, -1, '0, '0, -1, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
